// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST sequencer for a single-port SRAM macro.
// It drives the macro BIST port and checks read data through a READ_LAT-deep compare pipe.
module sram_march_bist_ctrl #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned READ_LAT = 1,
   parameter int unsigned ERRCNT_W = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic                abort_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                pass_o,
   output logic [ADDR_W-1:0]   fail_addr_o,
   output logic [2:0]          fail_elem_o,
   output logic [ERRCNT_W-1:0] err_cnt_o,
   output logic                bist_en_o,
   output logic                bist_men_o,
   output logic                bist_wen_o,
   output logic                bist_ren_o,
   output logic [ADDR_W-1:0]   bist_addr_o,
   output logic [DATA_W-1:0]   bist_din_o,
   output logic [DATA_W-1:0]   bist_bm_o,
   input  logic [DATA_W-1:0]   bist_dout_i
);

   localparam int unsigned DCNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam int unsigned LAST   = READ_LAT - 1;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   state_e              state_q;
   logic [2:0]          elem_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                op_q;
   logic                rd_exp_q;
   logic [DCNT_W-1:0]   drain_q;

   logic                pv_q [READ_LAT];
   logic                pd_q [READ_LAT];
   logic [ADDR_W-1:0]   pa_q [READ_LAT];
   logic [2:0]          pe_q [READ_LAT];

   logic                last_op_c, last_addr_c, run_end_c;
   logic [2:0]          nxt_elem_c;
   logic [ADDR_W-1:0]   nxt_addr_c;
   logic                nxt_op_c, nxt_wr_c, wr_bit_c, rd_bit_c;
   logic                mis_c;
   logic [ERRCNT_W-1:0] err_nxt_c;

   function automatic logic elem_down(input logic [2:0] e);
      return (e == 3'd3) || (e == 3'd4);
   endfunction

   // Counters hold the op currently on the port; compute the op that follows it.
   always_comb begin
      last_op_c   = (elem_q == 3'd0) || (elem_q == 3'd5) || op_q;
      last_addr_c = elem_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_MAX);
      run_end_c   = last_op_c && last_addr_c && (elem_q == 3'd5);
      nxt_elem_c  = elem_q;
      nxt_addr_c  = addr_q;
      nxt_op_c    = 1'b0;
      if (!last_op_c) begin
         nxt_op_c = 1'b1;
      end else if (!last_addr_c) begin
         nxt_addr_c = elem_down(elem_q) ? ADDR_W'(addr_q - 1'b1) : ADDR_W'(addr_q + 1'b1);
      end else begin
         nxt_elem_c = 3'(elem_q + 3'd1);
         nxt_addr_c = elem_down(3'(elem_q + 3'd1)) ? ADDR_MAX : '0;
      end
      nxt_wr_c = (nxt_elem_c == 3'd0) || ((nxt_elem_c != 3'd5) && nxt_op_c);
      rd_bit_c = (nxt_elem_c == 3'd2) || (nxt_elem_c == 3'd4);
      wr_bit_c = (nxt_elem_c != 3'd0) && !rd_bit_c;
   end

   always_comb begin
      mis_c     = pv_q[LAST] && (bist_dout_i != {DATA_W{pd_q[LAST]}});
      err_nxt_c = err_cnt_o;
      if (mis_c && !(&err_cnt_o)) err_nxt_c = err_cnt_o + ERRCNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         elem_q      <= '0;
         addr_q      <= '0;
         op_q        <= 1'b0;
         rd_exp_q    <= 1'b0;
         drain_q     <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         fail_addr_o <= '0;
         fail_elem_o <= '0;
         err_cnt_o   <= '0;
         bist_en_o   <= 1'b0;
         bist_men_o  <= 1'b0;
         bist_wen_o  <= 1'b0;
         bist_ren_o  <= 1'b0;
         bist_addr_o <= '0;
         bist_din_o  <= '0;
         bist_bm_o   <= '0;
         for (int i = 0; i < READ_LAT; i++) begin
            pv_q[i] <= 1'b0;
            pd_q[i] <= 1'b0;
            pa_q[i] <= '0;
            pe_q[i] <= '0;
         end
      end else if (abort_i) begin
         state_q    <= S_IDLE;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         pass_o     <= 1'b0;
         bist_en_o  <= 1'b0;
         bist_men_o <= 1'b0;
         bist_wen_o <= 1'b0;
         bist_ren_o <= 1'b0;
         bist_din_o <= '0;
         bist_bm_o  <= '0;
         for (int i = 0; i < READ_LAT; i++) pv_q[i] <= 1'b0;
      end else begin
         // Issued read enters the compare pipe at the edge the macro samples it.
         pv_q[0] <= bist_men_o & bist_ren_o;
         pd_q[0] <= rd_exp_q;
         pa_q[0] <= bist_addr_o;
         pe_q[0] <= elem_q;
         for (int i = 1; i < READ_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pd_q[i] <= pd_q[i-1];
            pa_q[i] <= pa_q[i-1];
            pe_q[i] <= pe_q[i-1];
         end
         if (mis_c) begin
            err_cnt_o <= err_nxt_c;
            if (err_cnt_o == '0) begin
               fail_addr_o <= pa_q[LAST];
               fail_elem_o <= pe_q[LAST];
            end
         end
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_q     <= S_RUN;
                  elem_q      <= '0;
                  addr_q      <= '0;
                  op_q        <= 1'b0;
                  rd_exp_q    <= 1'b0;
                  busy_o      <= 1'b1;
                  done_o      <= 1'b0;
                  pass_o      <= 1'b0;
                  err_cnt_o   <= '0;
                  fail_addr_o <= '0;
                  fail_elem_o <= '0;
                  bist_en_o   <= 1'b1;
                  bist_men_o  <= 1'b1;
                  bist_wen_o  <= 1'b1;
                  bist_ren_o  <= 1'b0;
                  bist_addr_o <= '0;
                  bist_din_o  <= '0;
                  bist_bm_o   <= '1;
                  for (int i = 0; i < READ_LAT; i++) pv_q[i] <= 1'b0;
               end
            end
            S_RUN: begin
               if (run_end_c) begin
                  state_q    <= S_DRAIN;
                  drain_q    <= '0;
                  bist_men_o <= 1'b0;
                  bist_wen_o <= 1'b0;
                  bist_ren_o <= 1'b0;
                  bist_din_o <= '0;
                  bist_bm_o  <= '0;
               end else begin
                  elem_q      <= nxt_elem_c;
                  addr_q      <= nxt_addr_c;
                  op_q        <= nxt_op_c;
                  rd_exp_q    <= rd_bit_c;
                  bist_men_o  <= 1'b1;
                  bist_wen_o  <= nxt_wr_c;
                  bist_ren_o  <= !nxt_wr_c;
                  bist_addr_o <= nxt_addr_c;
                  bist_din_o  <= {DATA_W{nxt_wr_c & wr_bit_c}};
                  bist_bm_o   <= {DATA_W{nxt_wr_c}};
               end
            end
            S_DRAIN: begin
               if (drain_q == DCNT_W'(LAST)) begin
                  state_q   <= S_DONE;
                  busy_o    <= 1'b0;
                  bist_en_o <= 1'b0;
                  done_o    <= 1'b1;
                  pass_o    <= (err_nxt_c == '0);
               end else begin
                  drain_q <= DCNT_W'(drain_q + 1'b1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
